pwm_tone_decoder: RTL and testbench

PWM_TONE_DECODER -- requirements
Module: pwm_tone_decoder

---
 rtl/pwm_tone_decoder.sv | 180 ++++++++++++++++++
 tb/tb_pwm_tone_decoder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_tone_decoder.sv
// rtl/pwm_tone_decoder.sv - PWM pair demodulator with zero-crossing period measurement and note decode
// One frame of 2^N ticks yields one sample; rising crossings of the sample stream time the tone in frames.
module pwm_tone_decoder #(
  parameter int N     = 8,
  parameter int HYST  = 8,
  parameter int TOL   = 1,
  parameter int P_D   = 54,
  parameter int P_E   = 48,
  parameter int P_FIS = 43,
  parameter int P_G   = 40,
  parameter int P_A   = 36,
  parameter int P_B   = 32,
  parameter int P_C   = 30,
  parameter int P_DH  = 27
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sample_tick,
  input  logic         pwm_pos,
  input  logic         pwm_neg,
  output logic [N:0]   sample,
  output logic         sample_valid,
  output logic [7:0]   period,
  output logic [3:0]   note_code,
  output logic         note_valid
);

  typedef enum logic {
    WAIT_NEG = 1'b0,
    ARMED    = 1'b1
  } cross_state_t;

  localparam logic [N-1:0]          FRAME_LAST = {N{1'b1}};
  localparam logic [N-1:0]          FRAME_ONE  = N'(1);
  localparam logic signed [N+1:0]   HYST_POS   = (N+2)'(HYST);
  localparam logic signed [N+1:0]   HYST_NEG   = -HYST_POS;

  logic [N-1:0]        frame_q, frame_d;
  logic [N:0]          pos_cnt_q, pos_cnt_d;
  logic [N:0]          neg_cnt_q, neg_cnt_d;
  logic [N:0]          sample_q, sample_d;
  logic                sample_valid_q, sample_valid_d;
  cross_state_t        state_q, state_d;
  logic [7:0]          per_cnt_q, per_cnt_d;
  logic                started_q, started_d;
  logic [7:0]          period_q, period_d;
  logic [3:0]          note_code_q, note_code_d;
  logic                note_valid_q, note_valid_d;

  logic signed [N+1:0] sample_s;
  logic [7:0]          per_inc;
  logic                rising;

  function automatic logic near(input logic [7:0] p, input int nom);
    logic [8:0] a;
    logic [8:0] b;
    logic [8:0] diff;
    a    = {1'b0, p};
    b    = 9'(nom);
    diff = (a >= b) ? (a - b) : (b - a);
    return diff <= 9'(TOL);
  endfunction

  // Checked from the highest note down so a period sitting between two
  // notes resolves to the shorter nominal period (31 decodes as C, not B).
  function automatic logic [3:0] decode(input logic [7:0] p);
    logic [3:0] code;
    code = 4'd0;
    if      (near(p, P_DH))  code = 4'd8;
    else if (near(p, P_C))   code = 4'd7;
    else if (near(p, P_B))   code = 4'd6;
    else if (near(p, P_A))   code = 4'd5;
    else if (near(p, P_G))   code = 4'd4;
    else if (near(p, P_FIS)) code = 4'd3;
    else if (near(p, P_E))   code = 4'd2;
    else if (near(p, P_D))   code = 4'd1;
    return code;
  endfunction

  assign sample_s = {sample_q[N], sample_q};
  assign per_inc  = per_cnt_q + 8'd1;

  always_comb begin
    frame_d        = frame_q;
    pos_cnt_d      = pos_cnt_q;
    neg_cnt_d      = neg_cnt_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    if (sample_tick) begin
      frame_d = frame_q + FRAME_ONE;
      if (frame_q == FRAME_LAST) begin
        // The closing tick's own high bits are folded in before the counters clear.
        sample_d       = (pos_cnt_q + {{N{1'b0}}, pwm_pos}) - (neg_cnt_q + {{N{1'b0}}, pwm_neg});
        pos_cnt_d      = '0;
        neg_cnt_d      = '0;
        sample_valid_d = 1'b1;
      end else begin
        pos_cnt_d = pos_cnt_q + {{N{1'b0}}, pwm_pos};
        neg_cnt_d = neg_cnt_q + {{N{1'b0}}, pwm_neg};
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    started_d    = started_q;
    period_d     = period_q;
    note_code_d  = note_code_q;
    note_valid_d = 1'b0;
    rising       = 1'b0;
    if (sample_valid_q) begin
      if (per_cnt_q != 8'hFF) per_cnt_d = per_inc;
      case (state_q)
        WAIT_NEG: begin
          if (sample_s < HYST_NEG) state_d = ARMED;
        end
        ARMED: begin
          if (sample_s > HYST_POS) begin
            state_d = WAIT_NEG;
            rising  = 1'b1;
          end
        end
        default: state_d = WAIT_NEG;
      endcase
      if (rising) begin
        per_cnt_d = '0;
        if (!started_q) begin
          started_d = 1'b1;
        end else begin
          period_d     = per_inc;
          note_code_d  = decode(per_inc);
          note_valid_d = 1'b1;
        end
      end else if (started_q && per_cnt_q == 8'd254) begin
        // Counter saturates this frame: report silence once and wait for a fresh crossing pair.
        period_d     = 8'hFF;
        note_code_d  = 4'd0;
        note_valid_d = 1'b1;
        started_d    = 1'b0;
        state_d      = WAIT_NEG;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q        <= '0;
      pos_cnt_q      <= '0;
      neg_cnt_q      <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      state_q        <= WAIT_NEG;
      per_cnt_q      <= '0;
      started_q      <= 1'b0;
      period_q       <= '0;
      note_code_q    <= '0;
      note_valid_q   <= 1'b0;
    end else begin
      frame_q        <= frame_d;
      pos_cnt_q      <= pos_cnt_d;
      neg_cnt_q      <= neg_cnt_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      state_q        <= state_d;
      per_cnt_q      <= per_cnt_d;
      started_q      <= started_d;
      period_q       <= period_d;
      note_code_q    <= note_code_d;
      note_valid_q   <= note_valid_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign period       = period_q;
  assign note_code    = note_code_q;
  assign note_valid   = note_valid_q;

endmodule

// File: tb/tb_pwm_tone_decoder.sv
// tb/tb_pwm_tone_decoder.sv - scoreboard bench for pwm_tone_decoder
// dut_a runs at N=8 for sample arithmetic; dut_b runs at N=4 so tone and timeout runs stay short.
module tb_pwm_tone_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       tick_a, pos_a, neg_a;
  logic [8:0] sample_a;
  logic       sv_a;
  logic [7:0] period_a;
  logic [3:0] code_a;
  logic       nv_a;

  logic       tick_b, pos_b, neg_b;
  logic [4:0] sample_b;
  logic       sv_b;
  logic [7:0] period_b;
  logic [3:0] code_b;
  logic       nv_b;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_sample_q[$];
  int exp_period_q[$];
  int exp_code_q[$];
  int nv_count  = 0;
  logic prev_sv_b = 1'b0;
  int started_m = 0;
  int prev_len  = 0;
  int prev_code = 0;

  pwm_tone_decoder #(.N(8)) dut_a (
    .clk(clk), .reset(reset), .sample_tick(tick_a), .pwm_pos(pos_a), .pwm_neg(neg_a),
    .sample(sample_a), .sample_valid(sv_a), .period(period_a), .note_code(code_a), .note_valid(nv_a)
  );

  pwm_tone_decoder #(.N(4), .HYST(4)) dut_b (
    .clk(clk), .reset(reset), .sample_tick(tick_b), .pwm_pos(pos_b), .pwm_neg(neg_b),
    .sample(sample_b), .sample_valid(sv_b), .period(period_b), .note_code(code_b), .note_valid(nv_b)
  );

  always @(negedge clk) begin
    if (sv_a === 1'b1) begin
      n_checks++;
      if (exp_sample_q.size() == 0) begin
        n_fail++;
        $display("FAIL sample_unexpected: sample_valid with sample %0d, required no strobe", $signed(sample_a));
      end else begin
        int e;
        e = exp_sample_q.pop_front();
        if ($signed(sample_a) !== e) begin
          n_fail++;
          $display("FAIL sample_value: got %0d, required %0d", $signed(sample_a), e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (nv_b === 1'b1) begin
      nv_count++;
      n_checks++;
      if (prev_sv_b !== 1'b1) begin
        n_fail++;
        $display("FAIL note_latency: sample_valid one cycle before note_valid was %b, required 1", prev_sv_b);
      end
      n_checks++;
      if (exp_period_q.size() == 0) begin
        n_fail++;
        $display("FAIL note_unexpected: note_valid with period %0d code %0d, required no strobe", period_b, code_b);
      end else begin
        int p;
        int c;
        p = exp_period_q.pop_front();
        c = exp_code_q.pop_front();
        if (period_b !== p[7:0]) begin
          n_fail++;
          $display("FAIL note_period: got %0d, required %0d", period_b, p);
        end
        n_checks++;
        if (code_b !== c[3:0]) begin
          n_fail++;
          $display("FAIL note_code: got %0d, required %0d (period %0d)", code_b, c, p);
        end
      end
    end
    prev_sv_b = sv_b;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic frame_a(input int npos, input int nneg, input bit gaps);
    bit early;
    early = 1'b0;
    exp_sample_q.push_back(npos - nneg);
    for (int i = 0; i < 256; i++) begin
      if (gaps && (i % 5 == 2)) begin
        tick_a = 1'b0; pos_a = 1'b1; neg_a = 1'b1;
        @(posedge clk); #1;
        if (sv_a) early = 1'b1;
      end
      tick_a = 1'b1; pos_a = (i < npos); neg_a = (i < nneg);
      @(posedge clk); #1;
      if (i < 255 && sv_a) early = 1'b1;
    end
    tick_a = 1'b0; pos_a = 1'b0; neg_a = 1'b0;
    n_checks++;
    if (sv_a !== 1'b1) begin
      n_fail++;
      $display("FAIL sample_valid_latency: strobe after closing tick was %b, required 1", sv_a);
    end
    n_checks++;
    if (early) begin
      n_fail++;
      $display("FAIL sample_valid_early: strobe seen before closing tick, required none");
    end
  endtask

  task automatic frame_b(input int val);
    for (int i = 0; i < 16; i++) begin
      tick_b = 1'b1;
      pos_b  = (val > 0) && (i < val);
      neg_b  = (val < 0) && (i < -val);
      @(posedge clk); #1;
    end
    tick_b = 1'b0; pos_b = 1'b0; neg_b = 1'b0;
  endtask

  // Each cycle starts on its rising crossing, so the crossing opening a cycle reports the previous cycle's length.
  task automatic tone_cycles(input int q, input int count, input int code);
    for (int k = 0; k < count; k++) begin
      if (started_m != 0) begin
        exp_period_q.push_back(prev_len);
        exp_code_q.push_back(prev_code);
      end
      for (int f = 0; f < q / 2; f++) frame_b(8);
      for (int f = q / 2; f < q; f++) frame_b(-8);
      started_m = 1;
      prev_len  = q;
      prev_code = code;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({sample_a, sv_a, period_a, code_a, nv_a} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_a: outputs %h, required 0", {sample_a, sv_a, period_a, code_a, nv_a});
    end
    n_checks++;
    if ({sample_b, sv_b, period_b, code_b, nv_b} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_b: outputs %h, required 0", {sample_b, sv_b, period_b, code_b, nv_b});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({sample_a, sv_a, period_a, code_a, nv_a} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_after_a: outputs %h, required 0", {sample_a, sv_a, period_a, code_a, nv_a});
    end
  endtask

  task automatic test_sample_frames;
    int rp;
    int rn;
    frame_a(200, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ($signed(sample_a) !== 200) begin
      n_fail++;
      $display("FAIL sample_hold: got %0d, required 200", $signed(sample_a));
    end
    frame_a(0, 256, 1'b0);
    frame_a(100, 100, 1'b0);
    frame_a(37, 201, 1'b1);
    for (int k = 0; k < 2; k++) begin
      rp = $urandom_range(0, 255);
      rn = $urandom_range(0, 255);
      frame_a(rp, rn, k[0]);
    end
    frame_a(90, 5, 1'b0);
  endtask

  task automatic test_reset_mid_frame;
    for (int i = 0; i < 120; i++) begin
      tick_a = 1'b1; pos_a = 1'b1; neg_a = 1'b0;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    tick_a = 1'b0; pos_a = 1'b0;
    n_checks++;
    if ({sample_a, sv_a, period_a, code_a, nv_a} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_mid_frame: outputs %h, required 0", {sample_a, sv_a, period_a, code_a, nv_a});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({sample_a, sv_a, period_a, code_a, nv_a} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_mid_frame_after: outputs %h, required 0", {sample_a, sv_a, period_a, code_a, nv_a});
    end
    frame_a(10, 3, 1'b0);
  endtask

  task automatic test_tone;
    int n;
    started_m = 0;
    frame_b(-8);
    tone_cycles(36, 4, 5);
    n = 0;
    while (exp_period_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (exp_period_q.size() != 0) begin
      n_fail++;
      $display("FAIL tone_drain: %0d notes outstanding, required 0", exp_period_q.size());
    end
  endtask

  task automatic test_note_match;
    tone_cycles(45, 2, 0);
    tone_cycles(31, 2, 7);
    tone_cycles(32, 2, 6);
    tone_cycles(54, 2, 1);
    tone_cycles(27, 2, 8);
    tone_cycles(48, 2, 2);
    tone_cycles(40, 2, 4);
    tone_cycles(43, 2, 3);
    tone_cycles(37, 2, 5);
    tone_cycles(38, 2, 0);
  endtask

  task automatic test_timeout;
    exp_period_q.push_back(255);
    exp_code_q.push_back(0);
    started_m = 0;
    nv_count  = 0;
    for (int f = 0; f < 300; f++) frame_b((f % 4 == 0) ? 4 : (f % 4 == 1) ? -4 : (f % 4 == 2) ? 0 : 3);
    n_checks++;
    if (nv_count != 1 || exp_period_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_pulse: %0d pulses with %0d outstanding, required 1 and 0", nv_count, exp_period_q.size());
    end
    for (int f = 0; f < 300; f++) frame_b((f % 2 == 0) ? -4 : 4);
    n_checks++;
    if (nv_count != 1) begin
      n_fail++;
      $display("FAIL timeout_silence: %0d pulses, required 1", nv_count);
    end
  endtask

  task automatic test_after_timeout;
    int n;
    frame_b(-8);
    tone_cycles(36, 3, 5);
    n = 0;
    while (exp_period_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (exp_period_q.size() != 0) begin
      n_fail++;
      $display("FAIL restart_drain: %0d notes outstanding, required 0", exp_period_q.size());
    end
  endtask

  initial begin
    reset  = 1'b1;
    tick_a = 1'b0; pos_a = 1'b0; neg_a = 1'b0;
    tick_b = 1'b0; pos_b = 1'b0; neg_b = 1'b0;
    test_reset;
    test_sample_frames;
    test_reset_mid_frame;
    test_tone;
    test_note_match;
    test_timeout;
    test_after_timeout;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (exp_sample_q.size() != 0) begin
      n_fail++;
      $display("FAIL sample_drain: %0d samples outstanding, required 0", exp_sample_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
